// File: rtl/sp_result_stage.sv
// sp_result_stage: classifies raw FP32 multiplier results into a stage-1 register and a 3-entry output FIFO.
// Optional exception counter enabled by defining SP_EXC_COUNT_EN.
`default_nettype none

module sp_result_stage #(
  parameter int DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_num1,
  input  logic [31:0] in_num2,
  input  logic [31:0] in_prod,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
`ifdef SP_EXC_COUNT_EN
  output logic [15:0] exc_count,
`endif
  output logic [3:0]  out_flags
);

  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [1:0]  LAST = 2'(DEPTH - 1);
  localparam logic [1:0]  FULL = 2'(DEPTH);

  logic [7:0]  e1, e2;
  logic [9:0]  exp_sum;
  logic        sgn, nan1, nan2, inf1, inf2, zero1, zero2;
  logic [31:0] cls_result;
  logic [3:0]  cls_flags;

  logic        s1_valid;
  logic [31:0] s1_result;
  logic [3:0]  s1_flags;

  logic [31:0] mem_result [DEPTH];
  logic [3:0]  mem_flags  [DEPTH];
  logic [1:0]  wr_ptr, rd_ptr, fifo_count, next_count;
  logic        accept, push, pop, full, next_s1, next_in_ready;

  assign e1      = in_num1[30:23];
  assign e2      = in_num2[30:23];
  assign exp_sum = {2'b00, e1} + {2'b00, e2};
  assign sgn     = in_num1[31] ^ in_num2[31];
  assign nan1    = (e1 == 8'hFF) && (in_num1[22:0] != 23'd0);
  assign nan2    = (e2 == 8'hFF) && (in_num2[22:0] != 23'd0);
  assign inf1    = (e1 == 8'hFF) && (in_num1[22:0] == 23'd0);
  assign inf2    = (e2 == 8'hFF) && (in_num2[22:0] == 23'd0);
  assign zero1   = (e1 == 8'h00);
  assign zero2   = (e2 == 8'h00);

  // Priority chain: first matching rule decides the result.
  always_comb begin
    cls_result = in_prod;
    cls_flags  = 4'b0000;
    if (nan1 || nan2) begin
      cls_result = QNAN;
      cls_flags  = 4'b1000;
    end else if ((inf1 && zero2) || (inf2 && zero1)) begin
      cls_result = QNAN;
      cls_flags  = 4'b1000;
    end else if (inf1 || inf2) begin
      cls_result = {sgn, 8'hFF, 23'd0};
      cls_flags  = 4'b0100;
    end else if (zero1 || zero2) begin
      cls_result = {sgn, 31'd0};
      cls_flags  = 4'b0001;
    end else if (exp_sum >= 10'd382) begin
      cls_result = {sgn, 8'hFF, 23'd0};
      cls_flags  = 4'b0100;
    end else if (exp_sum <= 10'd127) begin
      cls_result = {sgn, 31'd0};
      cls_flags  = 4'b0011;
    end
  end

  function automatic logic [1:0] bump(input logic [1:0] p);
    return (p == LAST) ? 2'd0 : p + 2'd1;
  endfunction

  assign full      = (fifo_count == FULL);
  assign out_valid = (fifo_count != 2'd0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign push      = s1_valid && (!full || pop);
  assign next_s1   = accept || (s1_valid && !push);

  always_comb begin
    next_count = fifo_count;
    if (push && !pop)
      next_count = fifo_count + 2'd1;
    else if (!push && pop)
      next_count = fifo_count - 2'd1;
  end

  // in_ready is registered from the post-edge occupancy, so out_ready never reaches it combinationally.
  assign next_in_ready = ({1'b0, next_count} + {2'b00, next_s1}) < 3'd3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_result  <= '0;
      s1_flags   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      in_ready   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_result[i] <= '0;
        mem_flags[i]  <= '0;
      end
    end else begin
      if (accept) begin
        s1_valid  <= 1'b1;
        s1_result <= cls_result;
        s1_flags  <= cls_flags;
      end else if (push) begin
        s1_valid  <= 1'b0;
      end
      if (push) begin
        mem_result[wr_ptr] <= s1_result;
        mem_flags[wr_ptr]  <= s1_flags;
        wr_ptr             <= bump(wr_ptr);
      end
      if (pop)
        rd_ptr <= bump(rd_ptr);
      fifo_count <= next_count;
      in_ready   <= next_in_ready;
    end
  end

  assign out_result = mem_result[rd_ptr];
  assign out_flags  = mem_flags[rd_ptr];

`ifdef SP_EXC_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      exc_count <= '0;
    else if (pop && (out_flags[3:1] != 3'd0) && (exc_count != 16'hFFFF))
      exc_count <= exc_count + 16'd1;
  end
`endif

endmodule

`default_nettype wire

// File: doc/sp_result_stage.md
SP_RESULT_STAGE -- requirements
Module: sp_result_stage

Interface
REQ-001 Parameter DEPTH, default 3, meaning output FIFO entries (fixed at 3; other values unsupported).
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  input beat present.
REQ-005 in_ready  output  1  stage can accept a beat this cycle.
REQ-006 in_num1  input  32  IEEE-754 single operand A, as fed to the multiplier.
REQ-007 in_num2  input  32  IEEE-754 single operand B.
REQ-008 in_prod  input  32  raw multiplier result {sign, exponent, mantissa} for in_num1, in_num2.
REQ-009 out_valid  output  1  result beat present.
REQ-010 out_ready  input  1  downstream accepts the beat.
REQ-011 out_result  output  32  corrected IEEE-754 single result.
REQ-012 out_flags  output  4  {invalid, overflow, underflow, zero}.
REQ-013 exc_count  output  16  exception counter; present only under the configuration macro.

Function
REQ-014 Input handshake SHALL occur when in_valid and in_ready are both high in the same cycle; output handshake SHALL occur when out_valid and out_ready are both high.
REQ-015 Accepted beats SHALL be classified into a single stage-1 register (s1_valid), then pushed into a 3-entry FIFO that drives out_*.
REQ-016 Latency from input handshake to out_valid SHALL be exactly 2 cycles when the FIFO is empty.
REQ-017 in_ready SHALL equal (fifo_count + s1_valid) < 3 and SHALL be driven from registers only, with no combinational path from out_ready.
REQ-018 With out_ready held high, the stage SHALL sustain one beat per cycle.
REQ-019 Classification: E = exponent field, M = mantissa field, s = sign(num1) XOR sign(num2), sum = E1 + E2 computed at 10 bits.
REQ-020 Classification priority, first match wins:
  - a NaN operand (E = 255, M != 0) -> 0x7FC00000, invalid;
  - inf × zero (E = 0 counts as zero, denormals included) -> 0x7FC00000, invalid;
  - an inf operand -> {s, 0xFF, 0}, overflow;
  - a zero operand -> {s, 31'b0}, zero;
  - sum >= 382 -> {s, 0xFF, 0}, overflow;
  - sum <= 127 -> {s, 31'b0}, underflow and zero;
  - otherwise -> in_prod unchanged, flags 0.
REQ-021 A NaN result SHALL always carry sign 0.
REQ-022 FIFO order SHALL be strictly preserved.
REQ-023 Simultaneous FIFO push and pop SHALL keep the count unchanged.
REQ-024 With the FIFO full and s1_valid high, s1 SHALL hold its beat until a pop occurs.
REQ-025 Pointers SHALL wrap from 2 to 0.

Reset
REQ-026 On rst, the following SHALL clear at the next clock edge: s1_valid, fifo_count, pointers, out_valid, in_ready, out_result, out_flags and exc_count.
REQ-027 Reset mid-operation SHALL discard all in-flight beats.
REQ-028 in_ready SHALL rise in the first cycle after rst deasserts.

Configuration
REQ-029 Macro SP_EXC_COUNT_EN SHALL control the exception counter.
REQ-030 With SP_EXC_COUNT_EN defined, exc_count SHALL increment by 1 on each output handshake whose flags[3:1] != 0, and SHALL saturate at 0xFFFF.
REQ-031 Without SP_EXC_COUNT_EN, the exc_count port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 Normal pass-through: num1 0x40400000, num2 0x40000000, prod 0x40C00000, out_ready = 1 -> two cycles later out_result 0x40C00000, out_flags 0000.
REQ-033 NaN input: num1 0x7FC00001, num2 0xBF800000 -> out_result 0x7FC00000, flags 1000; inf × zero: 0xFF800000 × 0x00000000 -> 0x7FC00000, flags 1000.
REQ-034 Overflow and underflow: 0x7F000000 × 0xFF000000 -> 0xFF800000, flags 0100; 0x00800000 × 0x00800000 -> 0x00000000, flags 0011.
REQ-035 Backpressure: out_ready = 0 while offering 5 beats -> exactly 3 accepted, after which in_ready = 0; raise out_ready -> all beats emerge in original order with no loss or duplication.
REQ-036 Reset mid-operation: assert rst with 3 beats buffered -> out_valid = 0 next cycle and nothing further emitted. With SP_EXC_COUNT_EN, 2 overflow results plus 1 normal result -> exc_count = 2.
